imem_boot_loader: RTL and testbench

- Boot-time controller that owns the write side of the 256-word instruction memory.
- Receives a program as a byte stream (valid/ready), assembles little-endian 32-bit words and writes them sequentially.
- Pads every unwritten entry with the halt instruction, then releases the CPU from hold.
- Sits between the board/UART byte receiver and the instruction memory. The CPU fetch path is untouched; the CPU stays held while loading.

---
 rtl/imem_boot_loader_pkg.sv | 28 ++
 rtl/imem_boot_loader_if.sv | 37 +++
 rtl/imem_boot_loader_packer.sv | 38 +++
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_pkg
// Description : Shared constants, state encoding and helpers for the loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_loader_pkg;

    localparam int          DEPTH      = 256;
    localparam int          ADDR_W     = 8;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0063;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        FILL = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic takes_bytes(input state_t s);
        return (s == HDR0) || (s == HDR1) || (s == DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Byte-stream, instruction-memory write and CPU control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if;
    import imem_boot_loader_pkg::*;

    logic              start;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err_oversize;
    logic [15:0]       words_loaded;

    // The loader is the slave of the byte stream and owns everything downstream.
    modport slave (
        input  start, byte_data, byte_valid,
        output byte_ready, mem_we, mem_waddr, mem_wdata,
        output cpu_hold, done, err_oversize, words_loaded
    );

    modport master (
        output start, byte_data, byte_valid,
        input  byte_ready, mem_we, mem_waddr, mem_wdata,
        input  cpu_hold, done, err_oversize, words_loaded
    );

endinterface
`default_nettype wire

// File: rtl/imem_boot_loader_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : byte_to_word_packer
// Description : Little-endian 4-byte assembler; o_word_valid flags the 4th byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_to_word_packer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clr,
    input  wire logic        i_accept,
    input  wire logic [7:0]  i_byte,
    output logic      [31:0] o_word,
    output logic             o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // Word is complete combinationally on the 4th byte so the write lands one cycle later.
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_accept && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a byte-streamed program into instruction memory, pads
//               the remainder with HALT_INSTR and then releases the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader (
    input  wire logic         clk,
    input  wire logic         rst,
    imem_boot_loader_if.slave bus
);
    import imem_boot_loader_pkg::*;

    localparam logic [15:0] c_DEPTH = 16'(DEPTH);
    localparam logic [15:0] c_LAST  = 16'(DEPTH - 1);

    state_t            r_state,  w_state_nxt;
    logic [7:0]        r_hdr_lo, w_hdr_lo_nxt;
    logic [15:0]       r_words,  w_words_nxt;
    logic [15:0]       r_idx,    w_idx_nxt;
    logic              r_err,    w_err_nxt;
    logic              r_we,     w_we_nxt;
    logic [ADDR_W-1:0] r_waddr,  w_waddr_nxt;
    logic [31:0]       r_wdata,  w_wdata_nxt;
    logic              r_done,   w_done_nxt;
    logic              r_hold,   w_hold_nxt;
    logic              r_ready,  w_ready_nxt;
    logic              w_pack_clr;

    logic              w_accept;
    logic [15:0]       w_hdr_n;
    logic [15:0]       w_idx_inc;
    logic [31:0]       w_word;
    logic              w_word_valid;

    assign w_accept  = bus.byte_valid && r_ready;
    assign w_hdr_n   = {bus.byte_data, r_hdr_lo};
    assign w_idx_inc = r_idx + 16'd1;

    byte_to_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_pack_clr),
        .i_accept     (w_accept && (r_state == DATA)),
        .i_byte       (bus.byte_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hdr_lo <= '0;
            r_words  <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_hold   <= 1'b1;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hdr_lo <= w_hdr_lo_nxt;
            r_words  <= w_words_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
            r_we     <= w_we_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_done   <= w_done_nxt;
            r_hold   <= w_hold_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hdr_lo_nxt = r_hdr_lo;
        w_words_nxt  = r_words;
        w_idx_nxt    = r_idx;
        w_err_nxt    = r_err;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_done_nxt   = 1'b0;
        w_hold_nxt   = 1'b1;
        w_pack_clr   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = HDR0;
            end
            HDR0: begin
                if (w_accept) begin
                    w_hdr_lo_nxt = bus.byte_data;
                    w_state_nxt  = HDR1;
                end
            end
            HDR1: begin
                if (w_accept) begin
                    w_words_nxt = w_hdr_n;
                    w_idx_nxt   = '0;
                    if (w_hdr_n == 16'd0) begin
                        w_state_nxt = FILL;
                    end else begin
                        // Oversize programs are still consumed in full, only the writes are dropped.
                        w_err_nxt   = (w_hdr_n > c_DEPTH);
                        w_pack_clr  = 1'b1;
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_valid) begin
                    if (r_idx < c_DEPTH) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_idx[ADDR_W-1:0];
                        w_wdata_nxt = w_word;
                    end
                    w_idx_nxt = w_idx_inc;
                    if (w_idx_inc == r_words)
                        w_state_nxt = (r_words < c_DEPTH) ? FILL : DONE;
                end
            end
            FILL: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = r_idx[ADDR_W-1:0];
                w_wdata_nxt = HALT_INSTR;
                if (r_idx == c_LAST) w_state_nxt = DONE;
                else                 w_idx_nxt   = w_idx_inc;
            end
            DONE: begin
                if (bus.start) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = HDR0;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_hold_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_ready_nxt = takes_bytes(w_state_nxt);
    end

    assign bus.byte_ready   = r_ready;
    assign bus.mem_we       = r_we;
    assign bus.mem_waddr    = r_waddr;
    assign bus.mem_wdata    = r_wdata;
    assign bus.cpu_hold     = r_hold;
    assign bus.done         = r_done;
    assign bus.err_oversize = r_err;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed scoreboard bench for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    imem_boot_loader_if bus ();

    imem_boot_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_got;
    logic [39:0] mon_exp;
    bit          mon_have;
    logic [31:0] prog2[$];
    logic [31:0] prog3[$];
    logic [31:0] prog_big[$];
    logic [31:0] prog_none[$];

    // Every observed write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mon_have = (exp_q.size() > 0);
            checks++;
            assert (mon_have === 1'b1) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr=%0d data=%h, expected no write",
                       bus.mem_waddr, bus.mem_wdata);
            end
            if (mon_have) begin
                mon_exp = exp_q.pop_front();
                mon_got = {bus.mem_waddr, bus.mem_wdata};
                checks++;
                assert (mon_got === mon_exp) else begin
                    errors++;
                    $error("FAIL write: observed addr=%0d data=%h, expected addr=%0d data=%h",
                           mon_got[39:32], mon_got[31:0], mon_exp[39:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_load(input int n, input logic [31:0] prog[$]);
        for (int i = 0; i < n && i < DEPTH; i++)
            exp_q.push_back({8'(i), prog[i]});
        for (int a = n; a < DEPTH; a++)
            exp_q.push_back({8'(a), HALT_INSTR});
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit got;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        got = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
        end
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_data  = b;
            got = bus.byte_ready;
            @(posedge clk);
            #1;
            bus.byte_valid = 1'b0;
        end
        check("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic send_load(input logic [15:0] n, input logic [31:0] prog[$], input int gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        for (int i = 0; i < int'(n); i++) send_word(prog[i], gap);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic [15:0] n, input logic err);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("cpu_hold_released", 32'(bus.cpu_hold), 32'd0);
        check("words_loaded", 32'(bus.words_loaded), 32'(n));
        check("err_oversize", 32'(bus.err_oversize), 32'(err));
        check("byte_ready_done", 32'(bus.byte_ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"},   32'(bus.cpu_hold),     32'd1);
        check({tag, "_done"},       32'(bus.done),         32'd0);
        check({tag, "_err"},        32'(bus.err_oversize), 32'd0);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready),   32'd0);
        check({tag, "_mem_we"},     32'(bus.mem_we),       32'd0);
        check({tag, "_mem_waddr"},  32'(bus.mem_waddr),    32'd0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,         32'd0);
        check({tag, "_words"},      32'(bus.words_loaded), 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        prog2 = '{32'h0000_0013, 32'h0010_0093};
        prog3 = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
        for (int i = 0; i < 257; i++) prog_big.push_back($urandom);

        // Reset, then idle for 100 cycles with no start.
        #1 rst = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_byte_ready", 32'(bus.byte_ready), 32'd0);

        // Two-word program with explicit write-latency checks.
        push_load(2, prog2);
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(prog2[0], 0);
        @(negedge clk);
        check("lat_w0_we", 32'(bus.mem_we), 32'd1);
        check("lat_w0_addr", 32'(bus.mem_waddr), 32'd0);
        send_word(prog2[1], 0);
        @(negedge clk);
        check("lat_w1_we", 32'(bus.mem_we), 32'd1);
        check("lat_w1_data", bus.mem_wdata, 32'h0010_0093);
        wait_done(400, 16'd2, 1'b0);

        // Reload with an empty program: pure HALT fill.
        do_start();
        check("reload_done_cleared", 32'(bus.done), 32'd0);
        check("reload_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        push_load(0, prog_none);
        send_load(16'd0, prog_none, 0);
        wait_done(400, 16'd0, 1'b0);

        // Oversize program: 257 words, only 256 written, no fill.
        do_start();
        push_load(257, prog_big);
        send_load(16'd257, prog_big, 0);
        wait_done(50, 16'd257, 1'b1);

        // Backpressured three-word load; reload must also clear the error flag.
        do_start();
        check("reload_err_cleared", 32'(bus.err_oversize), 32'd0);
        push_load(3, prog3);
        send_load(16'd3, prog3, 5);
        wait_done(400, 16'd3, 1'b0);

        // Reset in the middle of word 1, then a clean gap-free reload.
        do_start();
        push_load(3, prog3);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(prog3[0], 0);
        send_byte(prog3[1][7:0], 0);
        send_byte(prog3[1][15:8], 0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_load(3, prog3);
        do_start();
        send_load(16'd3, prog3, 0);
        wait_done(400, 16'd3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
